unidade_busca: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction memory ROM. It owns the program counter, drives the 12-bit PC address into the memory, and registers the returned 32-bit word into an instruction register for the decode/execute stage. It also applies redirects from the execute stage and stalls on input (IN) and halt (HLT) opcodes found in the fetched word.

---
 rtl/unidade_busca_if.sv | 37 +++
 rtl/unidade_busca.sv | 134 +++++++++++++
 tb/tb_unidade_busca.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/unidade_busca_if.sv
// Bus between the instruction fetch stage and its surroundings:
// the execute-stage controls, the instruction ROM and the decode stage.
// The fetch unit takes the slave modport. Whatever drives and observes
// it (the datapath, or a bench) takes the master modport.
//
// Transfer semantics: there is no back-pressure. "valida" is a
// qualifier only. instrucao carries a real fetched word in exactly the
// cycles where valida is high. The downstream stage must consume that
// word in the same cycle. "habilita" is the only way to stop fetch.
// When habilita is low, pc, instrucao and valida all hold their value.
// "estado" exposes the fetch FSM state for observation.
interface unidade_busca_if #(
  parameter int LARGURA_PC = 12
);
  logic                  habilita;
  logic                  desvio;
  logic [LARGURA_PC-1:0] endereco_desvio;
  logic                  confirma;
  logic [31:0]           instrucao_mem;
  logic [LARGURA_PC-1:0] pc;
  logic [31:0]           instrucao;
  logic                  valida;
  logic                  esperando;
  logic                  parado;
  logic [31:0]           contagem;
  logic [1:0]            estado;

  modport master (
    output habilita, desvio, endereco_desvio, confirma, instrucao_mem,
    input  pc, instrucao, valida, esperando, parado, contagem, estado
  );

  modport slave (
    input  habilita, desvio, endereco_desvio, confirma, instrucao_mem,
    output pc, instrucao, valida, esperando, parado, contagem, estado
  );
endinterface

// File: rtl/unidade_busca.sv
// unidade_busca: the instruction fetch stage in front of a combinational ROM.
// This module owns the PC. It registers the word the ROM returns into
// instrucao, one clock after the pc value. It applies redirects from
// execute as a one-bubble flush. It stops on IN until the operator
// confirms, and stops on HLT until reset.
// Optional build macro: CONTADOR_INSTRUCOES_EN. When it is defined, the
// module counts fetched instructions on contagem. When it is not
// defined, contagem is tied to zero.
module unidade_busca #(
  parameter int          LARGURA_PC       = 12,
  parameter logic [LARGURA_PC-1:0] ENDERECO_INICIAL = '0,
  parameter logic [4:0]  OPCODE_IN        = 5'd20,
  parameter logic [4:0]  OPCODE_HLT       = 5'd21,
  parameter logic [31:0] PALAVRA_NOP      = {5'd23, 27'd0}
) (
  input logic             clock,
  input logic             reset,
  unidade_busca_if.slave  bus
);

  typedef enum logic [1:0] {
    BUSCA  = 2'd0,
    ESPERA = 2'd1,
    PARADO = 2'd2
  } estado_t;

  localparam logic [LARGURA_PC-1:0] UM_PC = {{(LARGURA_PC-1){1'b0}}, 1'b1};

  estado_t               r_estado;
  estado_t               w_estado_prox;
  logic [LARGURA_PC-1:0] r_pc;
  logic [LARGURA_PC-1:0] w_pc_prox;
  logic [31:0]           r_instrucao;
  logic [31:0]           w_instrucao_prox;
  logic                  r_valida;
  logic                  w_valida_prox;
  logic [4:0]            w_op;

  // The opcode under test is in the word the ROM returns for the current pc.
  assign w_op = bus.instrucao_mem[31:27];

  // Next-state and next-register values. A redirect takes priority over
  // what the state would do. habilita gates fetch only while in BUSCA.
  always_comb begin
    w_estado_prox    = r_estado;
    w_pc_prox        = r_pc;
    w_instrucao_prox = r_instrucao;
    w_valida_prox    = r_valida;
    case (r_estado)
      BUSCA: begin
        if (bus.desvio) begin
          w_pc_prox        = bus.endereco_desvio;
          w_instrucao_prox = PALAVRA_NOP;
          w_valida_prox    = 1'b0;
        end else if (bus.habilita) begin
          w_instrucao_prox = bus.instrucao_mem;
          w_valida_prox    = 1'b1;
          if (w_op == OPCODE_HLT) begin
            // pc stays on the HLT word.
            w_estado_prox = PARADO;
          end else begin
            w_pc_prox = r_pc + UM_PC;
            if (w_op == OPCODE_IN) begin
              w_estado_prox = ESPERA;
            end
          end
        end
      end
      ESPERA: begin
        w_valida_prox = 1'b0;
        if (bus.desvio) begin
          w_pc_prox        = bus.endereco_desvio;
          w_instrucao_prox = PALAVRA_NOP;
          w_estado_prox    = BUSCA;
        end else if (bus.confirma) begin
          // No fetch happens on the confirming edge. Fetch resumes on the next edge.
          w_estado_prox = BUSCA;
        end
      end
      PARADO: begin
        // In PARADO, everything except reset is ignored.
        w_valida_prox = 1'b0;
      end
      default: begin
        w_estado_prox    = BUSCA;
        w_valida_prox    = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado    <= BUSCA;
      r_pc        <= ENDERECO_INICIAL;
      r_instrucao <= PALAVRA_NOP;
      r_valida    <= 1'b0;
    end else begin
      r_estado    <= w_estado_prox;
      r_pc        <= w_pc_prox;
      r_instrucao <= w_instrucao_prox;
      r_valida    <= w_valida_prox;
    end
  end

`ifdef CONTADOR_INSTRUCOES_EN
  logic        w_carrega;
  logic [31:0] r_contagem;

  // A fetch is counted on every edge that loads valida with 1.
  assign w_carrega = (r_estado == BUSCA) && !bus.desvio && bus.habilita;

  // Counts fetched instructions. It wraps naturally and only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contagem <= '0;
    end else if (w_carrega) begin
      r_contagem <= r_contagem + 32'd1;
    end
  end

  assign bus.contagem = r_contagem;
`else
  assign bus.contagem = 32'd0;
`endif

  assign bus.pc        = r_pc;
  assign bus.instrucao = r_instrucao;
  assign bus.valida    = r_valida;
  assign bus.esperando = (r_estado == ESPERA);
  assign bus.parado    = (r_estado == PARADO);
  assign bus.estado    = r_estado;

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca. It models the ROM as an array. The
// word fetched at each pc goes into an expected queue when the fetch is
// driven. The bench pops that word when instrucao is sampled.
module tb_unidade_busca;
  localparam int LARGURA_PC = 12;
  localparam logic [31:0] NOP_W = {5'd23, 27'd0};
  localparam logic [31:0] IN_W  = {5'd20, 27'd0};
  localparam logic [31:0] HLT_W = {5'd21, 27'd0};

  logic clock = 1'b0;
  logic reset;

  // Clock and reset
  always #5 clock = ~clock;

  unidade_busca_if #(.LARGURA_PC(LARGURA_PC)) bus ();

  unidade_busca #(.LARGURA_PC(LARGURA_PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:4095];
  assign bus.instrucao_mem = mem[bus.pc];

  logic [31:0]           exp_q [$];
  int                    checks = 0;
  int                    errors = 0;
  logic [LARGURA_PC-1:0] exp_pc;
  int unsigned           n_fetch;

  function automatic logic [31:0] exp_cont();
`ifdef CONTADOR_INSTRUCOES_EN
    return 32'(n_fetch);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expd);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Driver: one enabled edge in BUSCA on an ordinary word.
  task automatic fetch_step();
    exp_q.push_back(mem[exp_pc]);
    tick();
    exp_pc = exp_pc + 12'd1;
    n_fetch++;
    check("fetch_pc", 32'(bus.pc), 32'(exp_pc));
    check("fetch_valida", 32'(bus.valida), 32'd1);
    check("fetch_instrucao", bus.instrucao, exp_q.pop_front());
    check("fetch_contagem", bus.contagem, exp_cont());
  endtask

  // Driver: a one-cycle redirect pulse. It is a flush with one bubble.
  task automatic redirect(input logic [LARGURA_PC-1:0] alvo);
    bus.desvio = 1'b1;
    bus.endereco_desvio = alvo;
    tick();
    bus.desvio = 1'b0;
    bus.endereco_desvio = 12'($urandom);
    exp_pc = alvo;
    check("desvio_pc", 32'(bus.pc), 32'(alvo));
    check("desvio_instrucao", bus.instrucao, NOP_W);
    check("desvio_valida", 32'(bus.valida), 32'd0);
    check("desvio_esperando", 32'(bus.esperando), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.habilita = 1'b0;
    bus.desvio = 1'b0;
    bus.confirma = 1'b0;
    bus.endereco_desvio = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = {5'($urandom_range(0, 19)), 27'($urandom)};
    end
    mem[0]   = NOP_W;
    mem[130] = IN_W;
    mem[200] = IN_W;
    mem[177] = HLT_W;
    n_fetch = 0;
    exp_pc = 12'd0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_instrucao", bus.instrucao, NOP_W);
    check("rst_valida", 32'(bus.valida), 32'd0);
    check("rst_esperando", 32'(bus.esperando), 32'd0);
    check("rst_parado", 32'(bus.parado), 32'd0);
    check("rst_contagem", bus.contagem, 32'd0);

    // Sequential fetch from 0
    reset = 1'b0;
    bus.habilita = 1'b1;
    repeat (5) fetch_step();

    // Redirect at pc=5 to 19
    redirect(12'd19);
    fetch_step();

    // Stall for three cycles at pc=40
    redirect(12'd39);
    fetch_step();
    bus.habilita = 1'b0;
    repeat (3) begin
      tick();
      check("stall_pc", 32'(bus.pc), 32'd40);
      check("stall_instrucao", bus.instrucao, mem[39]);
      check("stall_valida", 32'(bus.valida), 32'd1);
    end
    bus.habilita = 1'b1;
    fetch_step();

    // PC wrap from 4095 to 0
    redirect(12'd4094);
    fetch_step();
    fetch_step();
    check("wrap_pc", 32'(bus.pc), 32'd0);

    // IN at 130: wait for confirma
    redirect(12'd130);
    fetch_step();
    check("in_esperando", 32'(bus.esperando), 32'd1);
    check("in_instrucao", bus.instrucao, IN_W);
    repeat (10) begin
      tick();
      check("espera_pc", 32'(bus.pc), 32'd131);
      check("espera_valida", 32'(bus.valida), 32'd0);
      check("espera_esperando", 32'(bus.esperando), 32'd1);
    end
    bus.confirma = 1'b1;
    tick();
    bus.confirma = 1'b0;
    check("confirma_esperando", 32'(bus.esperando), 32'd0);
    check("confirma_pc", 32'(bus.pc), 32'd131);
    check("confirma_valida", 32'(bus.valida), 32'd0);
    fetch_step();

    // confirma has no effect outside ESPERA
    bus.confirma = 1'b1;
    fetch_step();
    bus.confirma = 1'b0;

    // Redirect while waiting in ESPERA
    redirect(12'd200);
    fetch_step();
    check("in2_esperando", 32'(bus.esperando), 32'd1);
    tick();
    redirect(12'd19);
    fetch_step();

    // HLT at 177
    redirect(12'd177);
    exp_q.push_back(mem[177]);
    tick();
    n_fetch++;
    check("hlt_pc", 32'(bus.pc), 32'd177);
    check("hlt_valida", 32'(bus.valida), 32'd1);
    check("hlt_parado", 32'(bus.parado), 32'd1);
    check("hlt_instrucao", bus.instrucao, exp_q.pop_front());
    check("hlt_contagem", bus.contagem, exp_cont());
    repeat (6) begin
      bus.desvio = 1'($urandom_range(0, 1));
      bus.confirma = 1'($urandom_range(0, 1));
      bus.habilita = 1'($urandom_range(0, 1));
      bus.endereco_desvio = 12'($urandom);
      tick();
      check("parado_pc", 32'(bus.pc), 32'd177);
      check("parado_valida", 32'(bus.valida), 32'd0);
      check("parado_parado", 32'(bus.parado), 32'd1);
      check("parado_instrucao", bus.instrucao, HLT_W);
      check("parado_contagem", bus.contagem, exp_cont());
    end

    // Reset asserted asynchronously in the middle of PARADO
    #2;
    reset = 1'b1;
    #1;
    check("arst_pc", 32'(bus.pc), 32'd0);
    check("arst_parado", 32'(bus.parado), 32'd0);
    check("arst_valida", 32'(bus.valida), 32'd0);
    check("arst_instrucao", bus.instrucao, NOP_W);
    check("arst_contagem", bus.contagem, 32'd0);
    bus.desvio = 1'b0;
    bus.confirma = 1'b0;
    bus.habilita = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_fetch = 0;
    exp_pc = 12'd0;
    repeat (3) fetch_step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
